// File: rtl/pe_pkg.sv
// Shared definitions for the PE front-end sequencer: lane width, PE mode
// encodings and the sequencer state encoding.
package pe_pkg;

  localparam int PE_LANE_W = 16;

  localparam logic [1:0] PE_MODE_WUPD = 2'b00;
  localparam logic [1:0] PE_MODE_MVM  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WUPD  = 2'b01,
    ST_RUN   = 2'b10,
    ST_DRAIN = 2'b11
  } pe_state_e;

endpackage

// File: rtl/pe_lane_collector.sv
// Lane-indexed write register: each accepted word lands in the lane pointed
// to by a wrapping index. The full flag is set when the last lane is written
// and stays set until cleared. Lane contents are never cleared after use.
module pe_lane_collector
  import pe_pkg::*;
#(
  parameter int NLANES = 16,
  parameter int LANE_W = PE_LANE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [LANE_W-1:0]        wr_data,
  input  logic                     clr_full,
  output logic [NLANES*LANE_W-1:0] lanes,
  output logic                     wrap,
  output logic                     full
);

  localparam int               IDX_W    = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NLANES - 1);

  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NLANES*LANE_W-1:0] lanes_q, lanes_d;
  logic                     full_q, full_d;
  logic                     wrap_s;

  // Next-state for lane storage, write index and full flag.
  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    full_d  = full_q;
    wrap_s  = wr_en && (idx_q == IDX_LAST);
    if (wr_en) begin
      lanes_d[idx_q*LANE_W +: LANE_W] = wr_data;
      idx_d = wrap_s ? {IDX_W{1'b0}} : (idx_q + 1'b1);
    end else begin
      idx_d = idx_q;
    end
    // A completed frame sets the flag; the consumer clears it once used.
    if (wrap_s) begin
      full_d = 1'b1;
    end else if (clr_full) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q <= '0;
      idx_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
    end
  end

  assign lanes = lanes_q;
  assign wrap  = wrap_s;
  assign full  = full_q;

endmodule

// File: rtl/pe_sequencer.sv
// Front-end sequencer for one PE: assembles a 16-bit word stream into the
// PE's D/W buses, steps the PE through weight-update and block-MVM phases,
// then serialises the captured Q bus back out as 16-bit words.
module pe_sequencer
  import pe_pkg::*;
#(
  parameter int WIDTH      = PE_LANE_W,
  parameter int NDATA      = 16,
  parameter int NWEIGHT    = 64,
  parameter int RUN_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sel,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            ce,
  output logic [1:0]                      mode,
  output logic [WIDTH*NDATA-1:0]          D,
  output logic [WIDTH*NWEIGHT-1:0]        W,
  input  logic [WIDTH*(NWEIGHT/2)-1:0]    Q,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic                            busy
);

  localparam int                NOUT_W   = NWEIGHT / 2;
  localparam int                RC_W     = $clog2(RUN_CYCLES + 1);
  localparam logic [RC_W-1:0]   RUN_LAST = RC_W'(RUN_CYCLES - 1);
  localparam int                OI_W     = $clog2(NOUT_W);
  localparam logic [OI_W-1:0]   OUT_LAST = OI_W'(NOUT_W - 1);

  pe_state_e                   state_q, state_d;
  logic [RC_W-1:0]             run_cnt_q, run_cnt_d;
  logic [WIDTH*NOUT_W-1:0]     out_reg_q, out_reg_d;
  logic [OI_W-1:0]             out_idx_q, out_idx_d;
  logic                        out_valid_q, out_valid_d;
  logic [WIDTH-1:0]            out_data_q, out_data_d;
  logic                        ce_q, ce_d;
  logic [1:0]                  mode_q, mode_d;
  logic                        busy_q, busy_d;
  logic                        ready_en_q, ready_en_d;

  logic                        in_ready_s, accept_s;
  logic                        w_wr_s, d_wr_s;
  logic                        w_wrap_s, d_wrap_s;
  logic                        w_valid_s, d_full_s, d_clr_s;
  logic [OI_W-1:0]             nxt_idx_s;

  // ready_en_q keeps in_ready low during reset and releases it one edge later.
  // Data words stall while a data frame is waiting; weights always flow in IDLE.
  assign in_ready_s = ready_en_q && (state_q == ST_IDLE) && !(!in_sel && d_full_s);
  assign accept_s   = in_valid && in_ready_s;
  assign w_wr_s     = accept_s && in_sel;
  assign d_wr_s     = accept_s && !in_sel;

  pe_lane_collector #(.NLANES(NWEIGHT), .LANE_W(WIDTH)) u_w_coll (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_wr_s),
    .wr_data  (in_data),
    .clr_full (1'b0),
    .lanes    (W),
    .wrap     (w_wrap_s),
    .full     (w_valid_s)
  );

  // The weight collector's sticky full flag doubles as w_valid: it is set on
  // the frame-wrap edge that enters WUPD and is only consulted back in IDLE,
  // so it reads as "weights loaded into the PE" everywhere it matters.
  pe_lane_collector #(.NLANES(NDATA), .LANE_W(WIDTH)) u_d_coll (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (d_wr_s),
    .wr_data  (in_data),
    .clr_full (d_clr_s),
    .lanes    (D),
    .wrap     (d_wrap_s),
    .full     (d_full_s)
  );

  // Next-state, run counter, output serializer and registered PE controls.
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    out_reg_d   = out_reg_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    d_clr_s     = 1'b0;
    nxt_idx_s   = out_idx_q + 1'b1;
    ready_en_d  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        // Weight-frame wrap wins over a pending data frame.
        if (w_wrap_s) begin
          state_d = ST_WUPD;
        end else if ((d_full_s || d_wrap_s) && w_valid_s) begin
          state_d   = ST_RUN;
          run_cnt_d = RUN_LAST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WUPD: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (run_cnt_q == {RC_W{1'b0}}) begin
          out_reg_d   = Q;
          out_idx_d   = {OI_W{1'b0}};
          out_valid_d = 1'b1;
          out_data_d  = Q[WIDTH-1:0];
          d_clr_s     = 1'b1;
          state_d     = ST_DRAIN;
        end else begin
          run_cnt_d = run_cnt_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_idx_q == OUT_LAST) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            out_idx_d  = nxt_idx_s;
            out_data_d = out_reg_q[nxt_idx_s*WIDTH +: WIDTH];
          end
        end else begin
          out_idx_d = out_idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // PE controls are decoded from the next state so they are flop outputs.
    ce_d   = (state_d == ST_WUPD) || (state_d == ST_RUN);
    mode_d = (state_d == ST_WUPD) ? PE_MODE_WUPD : PE_MODE_MVM;
    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      run_cnt_q   <= '0;
      out_reg_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ce_q        <= 1'b0;
      mode_q      <= PE_MODE_MVM;
      busy_q      <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      out_reg_q   <= out_reg_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ce_q        <= ce_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      ready_en_q  <= ready_en_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign ce        = ce_q;
  assign mode      = mode_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed self-checking bench for pe_sequencer.
module tb_pe_sequencer;

  localparam int NDATA      = 16;
  localparam int NWEIGHT    = 64;
  localparam int NOUT       = NWEIGHT / 2;
  localparam int RUN_CYCLES = 4;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sel;
  logic [15:0]           in_data;
  logic                  ce;
  logic [1:0]            mode;
  logic [16*NDATA-1:0]   D;
  logic [16*NWEIGHT-1:0] W;
  logic [16*NOUT-1:0]    Q;
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           out_data;
  logic                  busy;

  int n_checks;
  int n_pass;

  pe_sequencer #(
    .WIDTH(16), .NDATA(NDATA), .NWEIGHT(NWEIGHT), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .ce(ce), .mode(mode), .D(D), .W(W), .Q(Q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_q(input logic [15:0] base);
    for (int k = 0; k < NOUT; k++) Q[k*16 +: 16] = base + 16'(k);
  endtask

  // Present one word from a posedge+1 point; returns at posedge+1 after acceptance.
  task automatic send(input logic sel, input logic [15:0] data);
    int n;
    n = 0;
    in_valid = 1'b1; in_sel = sel; in_data = data;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk_eq("send_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_phase();
    for (int c = 0; c < RUN_CYCLES; c++) begin
      @(negedge clk);
      chk_eq("run_ce", 64'(ce), 64'd1);
      chk_eq("run_mode", 64'(mode), 64'd1);
      chk_eq("run_out_valid", 64'(out_valid), 64'd0);
      chk_eq("run_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  // Drain all result words; bp=1 uses the 1,0,0 out_ready pattern.
  task automatic drain(input logic bp, input logic [15:0] base);
    int e;
    int cyc;
    logic ov;
    e = 0; cyc = 0;
    while (e < NOUT && cyc < 400) begin
      out_ready = bp ? ((cyc % 3) == 0) : 1'b1;
      @(negedge clk);
      ov = out_valid;
      chk_eq("drain_valid", 64'(ov), 64'd1);
      chk_eq("drain_data", 64'(out_data), 64'(base + 16'(e)));
      chk_eq("drain_ce", 64'(ce), 64'd0);
      if (ov && out_ready) e++;
      cyc++;
      @(posedge clk); #1;
    end
    chk_eq("drain_count", 64'(e), 64'(NOUT));
    out_ready = 1'b0;
    @(negedge clk);
    chk_eq("drain_done_valid", 64'(out_valid), 64'd0);
    chk_eq("drain_done_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 16'h0000;
    out_ready = 1'b0;
    set_q(16'h0000);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_ce", 64'(ce), 64'd0);
    chk_eq("rst_mode", 64'(mode), 64'd1);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
    chk_eq("rst_out_data", 64'(out_data), 64'd0);
    chk_eq("rst_in_ready", 64'(in_ready), 64'd0);
    chk_eq("rst_D_any", 64'(|D), 64'd0);
    chk_eq("rst_W_any", 64'(|W), 64'd0);
    rst = 1'b0;
    #1;
    chk_eq("rel_in_ready_pre", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk_eq("rel_in_ready", 64'(in_ready), 64'd1);

    // Weight load: 64 x 2F04
    for (int i = 0; i < NWEIGHT; i++) send(1'b1, 16'h2F04);
    @(negedge clk);
    chk_eq("wupd_ce", 64'(ce), 64'd1);
    chk_eq("wupd_mode", 64'(mode), 64'd0);
    chk_eq("wupd_busy", 64'(busy), 64'd1);
    chk_eq("wupd_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_eq("post_wupd_ce", 64'(ce), 64'd0);
    chk_eq("post_wupd_mode", 64'(mode), 64'd1);
    chk_eq("post_wupd_busy", 64'(busy), 64'd0);
    for (int k = 0; k < NWEIGHT; k++) chk_eq("w_lane_2f04", 64'(W[k*16 +: 16]), 64'h2F04);
    @(posedge clk); #1;

    // MVM 1: 16 x 0B2A, Q lane k = k, no backpressure
    set_q(16'h0000);
    for (int i = 0; i < NDATA; i++) send(1'b0, 16'h0B2A);
    run_phase();
    for (int k = 0; k < NDATA; k++) chk_eq("d_lane_0b2a", 64'(D[k*16 +: 16]), 64'h0B2A);
    drain(1'b0, 16'h0000);

    // MVM 2: reuse weights, distinct data, Q lane k = 0x40+k, backpressure
    set_q(16'h0040);
    for (int i = 0; i < NDATA; i++) send(1'b0, 16'h1300 + 16'(i));
    run_phase();
    chk_eq("w_persist", 64'(W[63*16 +: 16]), 64'h2F04);
    chk_eq("d_lane3_mvm2", 64'(D[3*16 +: 16]), 64'h1303);
    drain(1'b1, 16'h0040);

    // Reset in RUN cycle 2
    set_q(16'h0099);
    for (int i = 0; i < NDATA; i++) send(1'b0, 16'h0777);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_eq("midrst_ce", 64'(ce), 64'd0);
    chk_eq("midrst_mode", 64'(mode), 64'd1);
    chk_eq("midrst_busy", 64'(busy), 64'd0);
    chk_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    chk_eq("midrst_D_any", 64'(|D), 64'd0);
    chk_eq("midrst_W_any", 64'(|W), 64'd0);
    chk_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_eq("midrst_rel_ready", 64'(in_ready), 64'd1);
    repeat (8) begin
      @(negedge clk);
      chk_eq("midrst_no_ov", 64'(out_valid), 64'd0);
      chk_eq("midrst_no_ce", 64'(ce), 64'd0);
    end
    @(posedge clk); #1;

    // Data first, then a stalled 17th word, then weights
    set_q(16'h0200);
    for (int i = 0; i < NDATA; i++) send(1'b0, 16'h0100 + 16'(i));
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hDEAD;
    repeat (3) begin
      @(negedge clk);
      chk_eq("stall17_in_ready", 64'(in_ready), 64'd0);
      chk_eq("stall17_busy", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_eq("stall17_lane0", 64'(D[15:0]), 64'h0100);
    chk_eq("stall17_lane15", 64'(D[15*16 +: 16]), 64'h010F);
    in_sel = 1'b1;
    #1;
    chk_eq("df_weight_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < NWEIGHT; i++) send(1'b1, 16'h5000 + 16'(i));
    @(negedge clk);
    chk_eq("df_wupd_ce", 64'(ce), 64'd1);
    chk_eq("df_wupd_mode", 64'(mode), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_eq("df_idle_ce", 64'(ce), 64'd0);
    chk_eq("df_idle_mode", 64'(mode), 64'd1);
    @(posedge clk); #1;
    run_phase();
    chk_eq("df_w_lane0", 64'(W[15:0]), 64'h5000);
    chk_eq("df_w_lane63", 64'(W[63*16 +: 16]), 64'h503F);
    chk_eq("df_d_lane7", 64'(D[7*16 +: 16]), 64'h0107);
    drain(1'b0, 16'h0200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
